if_stage: RTL and testbench

Instruction fetch stage directly upstream of the decode stage (ID). Holds the program counter and issues in-order requests to the instruction memory port. Tags each returned word with its fetch address and buffers it in a 2-entry queue. Presents one instruction per cycle to ID, honours ID's stall, and redirects on a taken branch, discarding wrong-path fetches already in flight.

---
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: holds the PC, issues in-order imem requests and feeds a
// 2-entry {pc, inst} queue to ID; a taken branch flushes the queue and drops in-flight words.
module if_stage #(
  parameter int unsigned       W_INST   = 32,
  parameter int unsigned       W_ADDR   = 32,
  parameter logic [W_ADDR-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [W_ADDR-1:0] br_addr_i,
  output logic              imem_req_o,
  output logic [W_ADDR-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [W_INST-1:0] imem_rdata_i,
  output logic [W_INST-1:0] inst_o,
  output logic [W_ADDR-1:0] pc_o,
  output logic              inst_valid_o
);

  logic [W_ADDR-1:0] pc_q, pc_d;
  logic [W_ADDR-1:0] oq_addr_q [2];
  logic [W_ADDR-1:0] oq_addr_d [2];
  logic [1:0]        oq_cnt_q, oq_cnt_d;
  logic [W_ADDR-1:0] iq_pc_q   [2];
  logic [W_ADDR-1:0] iq_pc_d   [2];
  logic [W_INST-1:0] iq_inst_q [2];
  logic [W_INST-1:0] iq_inst_d [2];
  logic [1:0]        iq_cnt_q, iq_cnt_d;
  logic [1:0]        drop_q, drop_d;

  logic [2:0] used;
  logic       credit;
  logic       issue;
  logic       ret_drop;
  logic       ret_keep;
  logic       ret_any;
  logic       iq_pop;
  logic [1:0] oq_left;
  logic [1:0] iq_left;

  // Every slot a returning word could need is reserved before the request goes out.
  assign used        = {1'b0, oq_cnt_q} + {1'b0, iq_cnt_q} + {1'b0, drop_q};
  assign credit      = (used < 3'd2);
  assign imem_req_o  = credit & ~rst & ~br_taken_i;
  assign imem_addr_o = pc_q;
  assign issue       = imem_req_o & imem_gnt_i;

  assign ret_drop = imem_rvalid_i & (drop_q != 2'd0);
  assign ret_keep = imem_rvalid_i & (drop_q == 2'd0) & (oq_cnt_q != 2'd0);
  assign ret_any  = ret_drop | ret_keep;

  assign inst_valid_o = (iq_cnt_q != 2'd0);
  assign inst_o       = inst_valid_o ? iq_inst_q[0] : '0;
  assign pc_o         = inst_valid_o ? iq_pc_q[0]   : '0;
  assign iq_pop       = inst_valid_o & ~stall_i;

  always_comb begin
    pc_d      = pc_q;
    oq_addr_d = oq_addr_q;
    oq_cnt_d  = oq_cnt_q;
    iq_pc_d   = iq_pc_q;
    iq_inst_d = iq_inst_q;
    iq_cnt_d  = iq_cnt_q;
    drop_d    = drop_q;
    oq_left   = oq_cnt_q - {1'b0, ret_keep};
    iq_left   = iq_cnt_q - {1'b0, iq_pop};
    if (br_taken_i) begin
      // Wrong-path requests still in memory become drops; a word arriving now is discarded.
      pc_d     = br_addr_i & ~W_ADDR'(3);
      oq_cnt_d = 2'd0;
      iq_cnt_d = 2'd0;
      drop_d   = drop_q + oq_cnt_q - {1'b0, ret_any};
    end else begin
      if (issue) pc_d = pc_q + W_ADDR'(4);
      if (ret_drop) drop_d = drop_q - 2'd1;
      if (ret_keep) oq_addr_d[0] = oq_addr_q[1];
      if (issue) begin
        if (oq_left == 2'd0) oq_addr_d[0] = pc_q;
        else                 oq_addr_d[1] = pc_q;
      end
      oq_cnt_d = oq_left + {1'b0, issue};
      if (iq_pop) begin
        iq_pc_d[0]   = iq_pc_q[1];
        iq_inst_d[0] = iq_inst_q[1];
      end
      if (ret_keep) begin
        if (iq_left == 2'd0) begin
          iq_pc_d[0]   = oq_addr_q[0];
          iq_inst_d[0] = imem_rdata_i;
        end else begin
          iq_pc_d[1]   = oq_addr_q[0];
          iq_inst_d[1] = imem_rdata_i;
        end
      end
      iq_cnt_d = iq_left + {1'b0, ret_keep};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      oq_cnt_q <= 2'd0;
      iq_cnt_q <= 2'd0;
      drop_q   <= 2'd0;
    end else begin
      pc_q     <= pc_d;
      oq_cnt_q <= oq_cnt_d;
      iq_cnt_q <= iq_cnt_d;
      drop_q   <= drop_d;
    end
  end

  // Queue payloads are qualified by the counters, so they carry no reset.
  always_ff @(posedge clk) begin
    oq_addr_q <= oq_addr_d;
    iq_pc_q   <= iq_pc_d;
    iq_inst_q <= iq_inst_d;
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order memory with random latency and grant, plus a program-order
// reference of expected fetch addresses and consumed {pc, inst} pairs.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;

  if_stage #(
    .W_INST  (32),
    .W_ADDR  (32),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_addr_i    (br_addr_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .inst_valid_o (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int unsigned gnt_pct = 100;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int          last_due = 0;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] last_cons_pc = 32'h1;
  logic        wrap_seen = 1'b0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_inst = '0;
  logic        br_fired = 1'b0;
  int          n_cons = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then check and update the model.
  task automatic tick(input logic t_rst, input logic t_stall, input logic t_br,
                      input logic [31:0] t_baddr, input logic t_br_on_ret);
    logic        br;
    logic [31:0] tgt;
    int          lat;
    int          due;
    @(negedge clk);
    cyc++;
    rst        = t_rst;
    stall_i    = t_stall;
    imem_gnt_i = ($urandom_range(99) < gnt_pct);
    if (!t_rst && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    if (t_rst) begin
      mq_addr.delete();
      mq_due.delete();
      last_due = 0;
    end
    br         = t_br | (t_br_on_ret & imem_rvalid_i & (inst_valid_o === 1'b1));
    br_taken_i = br;
    br_addr_i  = t_baddr;
    br_fired   = br;
    tgt        = t_baddr & 32'hFFFF_FFFC;
    #1;
    if (inst_valid_o === 1'b0) begin
      check("idle_inst", 64'(inst_o), 64'd0);
      check("idle_pc", 64'(pc_o), 64'd0);
    end
    if (hold_prev) begin
      check("hold_valid", 64'(inst_valid_o), 64'd1);
      check("hold_pc", 64'(pc_o), 64'(prev_pc));
      check("hold_inst", 64'(inst_o), 64'(prev_inst));
    end
    if (t_rst || br) check("req_gated", 64'(imem_req_o), 64'd0);
    if (!t_rst) check("fetch_addr", 64'(imem_addr_o), 64'(exp_fetch));
    if (!t_rst && !br && inst_valid_o === 1'b1 && !t_stall) begin
      check("cons_pc", 64'(pc_o), 64'(exp_pc));
      check("cons_inst", 64'(inst_o), 64'(mem_word(exp_pc)));
      if (last_cons_pc == 32'hFFFF_FFFC && pc_o == 32'h0) wrap_seen = 1'b1;
      last_cons_pc = pc_o;
      exp_pc       = exp_pc + 32'd4;
      n_cons++;
    end
    if (!t_rst && !br && imem_req_o === 1'b1 && imem_gnt_i) begin
      lat = int'($urandom_range(lat_max, lat_min));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(exp_fetch);
      mq_due.push_back(due);
      exp_fetch = exp_fetch + 32'd4;
    end
    check("credit", 64'(mq_addr.size() <= 2), 64'd1);
    if (br) begin
      exp_pc       = tgt;
      exp_fetch    = tgt;
      last_cons_pc = 32'h1;
    end
    if (t_rst) begin
      exp_pc       = RESET_PC;
      exp_fetch    = RESET_PC;
      last_cons_pc = 32'h1;
    end
    hold_prev = (inst_valid_o === 1'b1) && t_stall && !br && !t_rst;
    prev_pc   = pc_o;
    prev_inst = inst_o;
  endtask

  task automatic wait_valid(input int limit, output int vcyc);
    vcyc = -1;
    for (int i = 0; i < limit && vcyc < 0; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      if (inst_valid_o === 1'b1) vcyc = cyc;
    end
  endtask

  initial begin
    int   g;
    int   n;
    int   v;
    logic found;
    logic [31:0] tgt_r;
    int unsigned r;
    rst           = 1'b1;
    stall_i       = 1'b0;
    br_taken_i    = 1'b0;
    br_addr_i     = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;

    // Reset, then a 1-cycle memory with permanent grant.
    repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    g = cyc;
    check("rst_valid", 64'(inst_valid_o), 64'd0);
    check("rst_req", 64'(imem_req_o), 64'd1);
    check("rst_addr", 64'(imem_addr_o), 64'(RESET_PC));
    wait_valid(8, v);
    check("first_lat", 64'(v - g), 64'd2);
    check("first_pc", 64'(pc_o), 64'(RESET_PC));
    repeat (12) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Five stalled cycles: output held, issue stops once the credit is used up.
    repeat (5) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("stall_req_drop", 64'(imem_req_o), 64'd0);
    check("stall_valid", 64'(inst_valid_o), 64'd1);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect with nothing in flight: target valid three cycles later.
    repeat (4) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("pre_redir_idle", 64'(mq_addr.size()), 64'd0);
    tick(1'b0, 1'b1, 1'b1, 32'h0000_0203, 1'b0);
    n = cyc;
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("redir_req", 64'(imem_req_o), 64'd1);
    check("redir_flush", 64'(inst_valid_o), 64'd0);
    wait_valid(8, v);
    check("redir_lat", 64'(v - n), 64'd3);
    check("redir_pc", 64'(pc_o), 64'h200);

    // Redirect with two requests outstanding in a slow memory.
    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      if (mq_addr.size() == 2) found = 1'b1;
    end
    check("two_outstanding", 64'(found), 64'd1);
    lat_min = 1;
    lat_max = 1;
    tick(1'b0, 1'b0, 1'b1, 32'h0000_0203, 1'b0);
    wait_valid(16, v);
    check("stale_dropped_pc", 64'(pc_o), 64'h200);
    repeat (6) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect in the cycle a word returns while ID stalls.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0000_0303, 1'b1);
      if (br_fired) begin
        found = 1'b1;
        n     = cyc;
      end
    end
    check("samecyc_fire", 64'(found), 64'd1);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("samecyc_req", 64'(imem_req_o), 64'd1);
    check("samecyc_flush", 64'(inst_valid_o), 64'd0);
    wait_valid(8, v);
    check("samecyc_lat", 64'(v - n), 64'd3);
    check("samecyc_pc", 64'(pc_o), 64'h300);

    // Address wrap at the top of the address space.
    tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (12) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap", 64'(wrap_seen), 64'd1);

    // Reset with one request outstanding.
    lat_min = 2;
    lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      if (mq_addr.size() == 1) found = 1'b1;
    end
    check("one_outstanding", 64'(found), 64'd1);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("midrst_valid", 64'(inst_valid_o), 64'd0);
    check("midrst_addr", 64'(imem_addr_o), 64'(RESET_PC));
    check("midrst_req", 64'(imem_req_o), 64'd1);
    wait_valid(10, v);
    check("midrst_pc", 64'(pc_o), 64'(RESET_PC));

    // Randomised traffic: grant, latency, stall, redirect and occasional reset.
    gnt_pct = 70;
    lat_min = 1;
    lat_max = 3;
    n_cons  = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(999);
      tgt_r = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      tick(r < 3, $urandom_range(99) < 30, (r >= 3) && (r < 45), tgt_r, 1'b0);
    end
    check("progress", 64'(n_cons > 100), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
